uart_rx16: RTL and testbench

UART_RX16 -- requirements
Module: uart_rx16

---
 rtl/uart_rx16.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx16.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx16.sv
// uart_rx16 -- 16x oversampling UART receiver.
// The serial line is double-flopped, a start bit is confirmed at mid-bit,
// and each data bit and the stop bit are sampled at the centre of their bit.
// A stop bit sampled low reports a framing error and parks the receiver in
// BREAK until the line returns high.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data and the stop bit, and the parity_err output.
module uart_rx16 #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud16,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        PARITY = 3'd5
`endif
    } state_t;

    state_t               state, state_next;
    logic                 rx_meta, rx_sync;
    logic [3:0]           tick_cnt, tick_next;
    logic [BIT_W-1:0]     bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_next;
    logic                 valid_next;
    logic                 ferr_next;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad, pbad_next;
    logic                 perr_next;
`endif

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            tick_cnt   <= tick_next;
            bit_cnt    <= bit_next;
            shift_reg  <= shift_next;
            rx_data    <= data_next;
            rx_valid   <= valid_next;
            frame_err  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            parity_bad <= pbad_next;
            parity_err <= perr_next;
`endif
        end
    end

    // Next-state logic; nothing moves except on a baud16 tick, and the
    // pulse outputs fall back to zero on every clock that does not decide.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        data_next  = rx_data;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_next  = parity_bad;
        perr_next  = 1'b0;
`endif
        if (baud16) begin
            tick_next = tick_cnt + 4'd1;
            case (state)
                IDLE: begin
                    tick_next = '0;
                    if (!rx_sync) begin
                        state_next = START;
                    end
                end
                START: begin
                    if (tick_cnt == 4'd7) begin
                        if (rx_sync) begin
                            state_next = IDLE;
                        end else begin
                            tick_next  = '0;
                            bit_next   = '0;
                            state_next = DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick_cnt == 4'd15) begin
                        shift_next = {rx_sync, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_next = '0;
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            bit_next = bit_cnt + BIT_W'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt == 4'd15) begin
                        pbad_next  = (^shift_reg) ^ rx_sync;
                        state_next = STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick_cnt == 4'd15) begin
                        if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
                            if (parity_bad) begin
                                perr_next = 1'b1;
                            end else begin
                                data_next  = shift_reg;
                                valid_next = 1'b1;
                            end
`else
                            data_next  = shift_reg;
                            valid_next = 1'b1;
`endif
                            state_next = IDLE;
                        end else begin
                            ferr_next  = 1'b1;
                            state_next = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_sync) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Busy whenever a frame or a break is in progress.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx16.sv
// tb_uart_rx16 -- directed bench for uart_rx16.
// baud16 pulses every 4 clocks, so one bit lasts 64 clocks. Build with
// UART_RX_PARITY_EN defined to exercise the parity variant as well.
module tb_uart_rx16;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud16 = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         errors = 0;
    int         checks = 0;
    int         valid_count = 0;
    int         ferr_count = 0;
    int         perr_count = 0;
    logic [7:0] cap_q[$];
    logic [1:0] div = 2'd0;

    uart_rx16 #(.DATA_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .baud16    (baud16),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    // 100 MHz-style clock.
    always #5 clk = ~clk;

    // One-clock baud16 pulse every fourth clock, changed away from the edge.
    always @(negedge clk) begin
        div = div + 2'd1;
        baud16 = (div == 2'd0);
    end

    // Count every cycle each pulse output is high, and record delivered bytes.
    always @(posedge clk) begin
        #1;
        if (rx_valid === 1'b1) begin
            valid_count++;
            cap_q.push_back(rx_data);
        end
        if (frame_err === 1'b1) ferr_count++;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) perr_count++;
`endif
    end

    task automatic clear_counts();
        valid_count = 0;
        ferr_count = 0;
        perr_count = 0;
        cap_q.delete();
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Drive one frame: start, data LSB first, (even parity), stop.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^data);
`endif
        send_bit(stop_bit);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_data: got %0h expected 0", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
        checks++; if (valid_count !== 0) begin errors++; $display("[TB] FAIL idle_valid: got %0d pulses expected 0", valid_count); end
    endtask

    task automatic test_basic();
        clear_counts();
        send_bit(1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_mid: got %b expected 1", busy); end
        for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h01) != 8'h00);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        send_bit(1'b1);
        send_bit(1'b1);
        checks++; if (valid_count !== 1) begin errors++; $display("[TB] FAIL basic_valid_count: got %0d expected 1", valid_count); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL basic_rx_data: got %0h expected a5", rx_data); end
        checks++; if ((cap_q.size() > 0 ? cap_q[0] : 8'hxx) !== 8'hA5) begin errors++; $display("[TB] FAIL basic_captured: got %0h expected a5", (cap_q.size() > 0 ? cap_q[0] : 8'hxx)); end
        checks++; if (ferr_count !== 0) begin errors++; $display("[TB] FAIL basic_frame_err: got %0d expected 0", ferr_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_false_start();
        clear_counts();
        rx = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL false_busy_start: got %b expected 1", busy); end
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL false_busy_idle: got %b expected 0", busy); end
        checks++; if (valid_count !== 0) begin errors++; $display("[TB] FAIL false_valid: got %0d expected 0", valid_count); end
        checks++; if (ferr_count !== 0) begin errors++; $display("[TB] FAIL false_frame_err: got %0d expected 0", ferr_count); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL false_rx_data: got %0h expected a5", rx_data); end
    endtask

    task automatic test_break();
        clear_counts();
        applyStimulus(8'h3C, 1'b0);
        repeat (39 * BIT_CLKS) @(negedge clk);
        checks++; if (ferr_count !== 1) begin errors++; $display("[TB] FAIL break_frame_err: got %0d expected 1", ferr_count); end
        checks++; if (valid_count !== 0) begin errors++; $display("[TB] FAIL break_valid: got %0d expected 0", valid_count); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL break_rx_data: got %0h expected a5", rx_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL break_busy: got %b expected 1", busy); end
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL break_release: got %b expected 0", busy); end
        clear_counts();
        applyStimulus(8'h5A, 1'b1);
        send_bit(1'b1);
        checks++; if (valid_count !== 1) begin errors++; $display("[TB] FAIL recover_valid: got %0d expected 1", valid_count); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("[TB] FAIL recover_rx_data: got %0h expected 5a", rx_data); end
        checks++; if (ferr_count !== 0) begin errors++; $display("[TB] FAIL recover_frame_err: got %0d expected 0", ferr_count); end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        send_bit(1'b1);
        checks++; if (valid_count !== 2) begin errors++; $display("[TB] FAIL b2b_valid_count: got %0d expected 2", valid_count); end
        checks++; if ((cap_q.size() > 0 ? cap_q[0] : 8'hxx) !== 8'h00) begin errors++; $display("[TB] FAIL b2b_first: got %0h expected 00", (cap_q.size() > 0 ? cap_q[0] : 8'hxx)); end
        checks++; if ((cap_q.size() > 1 ? cap_q[1] : 8'hxx) !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_second: got %0h expected ff", (cap_q.size() > 1 ? cap_q[1] : 8'hxx)); end
        checks++; if (ferr_count !== 0) begin errors++; $display("[TB] FAIL b2b_frame_err: got %0d expected 0", ferr_count); end
    endtask

    task automatic test_reset_abort();
        clear_counts();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL abort_rx_data: got %0h expected 00", rx_data); end
        reset = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++; if (valid_count !== 0) begin errors++; $display("[TB] FAIL abort_valid: got %0d expected 0", valid_count); end
        checks++; if (ferr_count !== 0) begin errors++; $display("[TB] FAIL abort_frame_err: got %0d expected 0", ferr_count); end
        applyStimulus(8'h81, 1'b1);
        send_bit(1'b1);
        checks++; if (valid_count !== 1) begin errors++; $display("[TB] FAIL restart_valid: got %0d expected 1", valid_count); end
        checks++; if (rx_data !== 8'h81) begin errors++; $display("[TB] FAIL restart_rx_data: got %0h expected 81", rx_data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_counts();
        applyStimulus(8'h03, 1'b1);
        send_bit(1'b1);
        checks++; if (valid_count !== 1) begin errors++; $display("[TB] FAIL parity_good_valid: got %0d expected 1", valid_count); end
        checks++; if (rx_data !== 8'h03) begin errors++; $display("[TB] FAIL parity_good_data: got %0h expected 03", rx_data); end
        checks++; if (perr_count !== 0) begin errors++; $display("[TB] FAIL parity_good_err: got %0d expected 0", perr_count); end
        clear_counts();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h03 >> i) & 8'h01) != 8'h00);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++; if (perr_count !== 1) begin errors++; $display("[TB] FAIL parity_bad_err: got %0d expected 1", perr_count); end
        checks++; if (valid_count !== 0) begin errors++; $display("[TB] FAIL parity_bad_valid: got %0d expected 0", valid_count); end
        checks++; if (ferr_count !== 0) begin errors++; $display("[TB] FAIL parity_bad_frame_err: got %0d expected 0", ferr_count); end
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_false_start();
        test_break();
        test_back_to_back();
        test_reset_abort();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
